i2c_ram_slave: RTL and testbench
================================

# i2c_ram_slave

I2C target that exposes a 256-entry byte memory to an external I2C controller. It is the initiator on the single-port RAM port: it drives addr/wdata/we/re and consumes rdata. It decodes START, STOP and repeated START, then matches a 7-bit device address. The first written byte loads an internal pointer; later bytes write, or read with auto-increment. The block sits between the board-level SDA/SCL pads and the RAM instance, so the I2C master bench can run against a real target.

## Interface
- `DEV_ADDR`, 7'h50, 7-bit I2C device address answered.
- `N`, 8, data/address width of the RAM port (fixed at 8 for I2C byte transfers).
- `clk` input 1: system clock; must be ≥16× SCL frequency.
- `rst` input 1: reset, asynchronous and active-high.
- `scl_i` input 1: SCL pad input (asynchronous).
- `sda_i` input 1: SDA pad input (asynchronous).
- `sda_oe` output 1: 1 = pull SDA low (open-drain); 0 = release.
- `mem_addr` output N: RAM address.
- `mem_wdata` output N: RAM write data.
- `mem_we` output 1: RAM write strobe, one-cycle pulse.
- `mem_re` output 1: RAM read strobe, one-cycle pulse; never asserted together with `mem_we`.
- `mem_rdata` input N: RAM read data, valid the clk edge after `mem_re`.
- `busy` output 1: high from an address match until STOP.

## Operation
- **Input synchronisation:** SCL and SDA pass through a 2-flop synchronizer.
  - SCL rise/fall and SDA rise/fall are derived from the synchronized values.
- **Bus conditions:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state.
- **States:** IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
- **Bit handling:**
  - Data bits are sampled on SCL rise, MSB first.
  - `sda_oe` changes only on SCL fall.
- **START (including repeated START)** → DEV, bit counter cleared.
- **STOP** → IDLE, `sda_oe`=0, `busy`=0.
- **DEV:**
  - After 8 bits, the upper 7 are compared to `DEV_ADDR`.
  - Mismatch → IDLE, no ACK, no memory access until the next START.
  - Match → DEV_ACK; ACK is driven low for the 9th clock.
  - R/W=0 → PTR. R/W=1 → RD.
- **PTR:** the byte loads the pointer, then PTR_ACK (ACK driven), then WR.
- **WR:**
  - After the 8th bit: `mem_we` pulses one cycle with `mem_addr`=pointer and `mem_wdata`=byte.
  - The pointer increments the next cycle.
  - Then WR_ACK (ACK driven), then WR.
- **RD prefetch:** `mem_re` pulses with `mem_addr`=pointer at the SCL rise of the preceding ACK bit. `mem_rdata` is loaded into the TX shift register on the following cycle.
- **RD transmit:** bit7 is driven at the SCL fall that ends the ACK clock. For each bit, `sda_oe` = ~bit.
- **RD → RD_ACK:** after 8 bits, SDA is released and the pointer increments. The controller's ACK/NACK is sampled on SCL rise.
  - ACK (SDA=0) → prefetch pointer, RD.
  - NACK → IDLE-wait (SDA released) until STOP/START.
- **Pointer:** 8-bit, wraps 8'hFF→8'h00. It persists across transactions and is cleared only by `rst`.
- **Partial bytes:** a byte cut short by START/STOP is discarded; no `mem_we` is issued.

## Timing
- **Reset values:** `sda_oe`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0, `busy`=0, pointer=0, state=IDLE.
- **`rst` assertion:** outputs take their reset values immediately (asynchronous), including mid-transfer.
- **Input latency:** 2 clk from pad to synchronized value, 3 clk to the edge pulse.
- **Write strobe:** `mem_we` comes 1 clk after the synchronized SCL rise of bit 0.
- **Read path:** `mem_re` to data in the shift register is 2 clk, always completed before the next SCL fall.
- **ACK release:** `sda_oe` is released on the first SCL fall after the ACK clock, unless a data bit 0 follows.

## Configuration
- `I2C_RAM_SLAVE_GLITCH_FILTER_EN` defined:
  - Each synchronized line passes through a filter.
  - The filtered value changes only after 3 consecutive identical samples.
  - Adds 2 clk of input latency.
- Undefined: only the 2-flop synchronizer; pulses ≥1 clk are seen as edges.

## Structure
- **Package `i2c_pkg`:** state enum type, ACK/NACK constants, and the default `DEV_ADDR`.
- **Sub-module `i2c_line_sync`:** one instance per line.
  - Contains the synchronizer, the optional glitch filter, and rise/fall pulse generation.
- **Top module:** FSM, bit counter, shift registers, pointer, RAM strobes.

## Test plan
- **Write:** START, 0xA0, 0x10, 0xAB, 0xCD, STOP → ACK on all 4 bytes; `mem_we` with (0x10,0xAB), then (0x11,0xCD).
- **Random read:** preload 0x10=0xAB, 0x11=0xCD. START, 0xA0, 0x10, repeated START, 0xA1, read with ACK then NACK, STOP → `mem_re` at 0x10 then 0x11; SDA carries 0xAB, 0xCD; `sda_oe`=0 after NACK.
- **Address mismatch:** START, 0xA2, 0x00, STOP → no ACK, `sda_oe` never 1, no `mem_we`/`mem_re`, `busy`=0.
- **Wrap:** pointer 0xFF, write 0x11, 0x22 → writes at 0xFF then 0x00.
- **Aborted byte:** STOP after 4 bits of a data byte → no `mem_we`, state IDLE; the next transaction is ACKed normally.
- **Reset mid-read:** `rst` asserted while driving a 0 bit → `sda_oe`=0 with no clk edge. A following write to 0x05 is ACKed and written.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C RAM target: FSM state encoding,
// ACK/NACK line levels and the default device address.
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

  // SDA levels seen during the 9th clock of a byte
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK
  } state_e;

endpackage

// File: rtl/i2c_ram_slave_if.sv
// Single-port RAM port driven by the I2C target. The target is the master
// (drives address/strobes), the RAM instance is the slave.
interface i2c_ram_slave_if #(
  parameter int N = 8
);
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic         mem_re;
  logic [N-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Pad-input conditioner for one I2C line: 2-flop synchronizer, optional
// 3-sample glitch filter (I2C_RAM_SLAVE_GLITCH_FILTER_EN), rise/fall pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q;
  logic filt;
  logic prev_q, rise_q, fall_q;

  // NOTE: synchronizer flops reset to 1 (idle bus level) so leaving reset
  // never fabricates a falling edge that could look like START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_RAM_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Value moves only once three consecutive samples agree
  always_comb begin
    filt = filt_q;
    if (sync2_q == hist_q[0] && hist_q[0] == hist_q[1]) filt = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      filt_q <= filt;
    end
  end
`else
  assign filt = sync2_q;
`endif

  // level_o is the delayed copy so it lines up with the registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= filt;
      rise_q <= filt & ~prev_q;
      fall_q <= ~filt & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_ram_slave.sv
// I2C target exposing a 256-byte RAM: device-address match, pointer load,
// auto-incrementing writes/reads. Optional input glitch filter via
// I2C_RAM_SLAVE_GLITCH_FILTER_EN.
module i2c_ram_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         N        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            sda_oe,
  output logic            busy,
  i2c_ram_slave_if.master mem_bus
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (scl_i),
    .level_o (scl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (sda_i),
    .level_o (sda),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] rx_q, rx_d, rx_byte;
  logic [N-1:0] tx_q, tx_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         rw_q, rw_d;
  logic         sda_oe_q, sda_oe_d;
  logic         busy_q, busy_d;
  logic         we_q, we_d;
  logic         re_q, re_d;
  logic         load_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      re_q     <= re_d;
      load_q   <= re_q;
    end
  end

  // Bit counter runs 0..7 for data bits; 8 and 9 mark the two halves of the
  // ACK clock (before/after its rising edge).
  // NOTE: every _d gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    rx_byte  = {rx_q[N-2:0], sda};

    if (load_q) tx_d = mem_bus.mem_rdata;
    if (we_q)   ptr_d = ptr_q + N'(1);

    if (start_cond) begin
      state_d  = ST_DEV;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_cond) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_PTR, ST_WR: begin
          if (scl_rise) begin
            rx_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == ST_DEV) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ST_DEV_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte;
                state_d = ST_PTR_ACK;
              end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = rx_byte;
                state_d = ST_WR_ACK;
              end
            end
          end
        end

        ST_DEV_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall && cnt_q == 4'd8) sda_oe_d = 1'b1;
          if (scl_rise && cnt_q == 4'd8) begin
            cnt_d = 4'd9;
            // Read address phase: prefetch so bit 7 is ready at the next fall
            if (state_q == ST_DEV_ACK && rw_q) begin
              re_d   = 1'b1;
              addr_d = ptr_q;
            end
          end
          if (scl_fall && cnt_q == 4'd9) begin
            cnt_d = '0;
            if (state_q == ST_DEV_ACK && rw_q) begin
              state_d  = ST_RD;
              sda_oe_d = ~tx_q[N-1];
            end else begin
              state_d  = (state_q == ST_DEV_ACK) ? ST_PTR : ST_WR;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_RD: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
            tx_d  = {tx_q[N-2:0], 1'b0};
            if (cnt_q == 4'd7) begin
              state_d = ST_RD_ACK;
              ptr_d   = ptr_q + N'(1);
            end
          end
          if (scl_fall) sda_oe_d = ~tx_q[N-1];
        end

        ST_RD_ACK: begin
          if (scl_fall && cnt_q == 4'd8) sda_oe_d = 1'b0;
          if (scl_rise && cnt_q == 4'd8) begin
            if (sda == ACK) begin
              re_d   = 1'b1;
              addr_d = ptr_q;
              cnt_d  = 4'd9;
            end else begin
              state_d = ST_IDLE;
            end
          end
          if (scl_fall && cnt_q == 4'd9) begin
            state_d  = ST_RD;
            cnt_d    = '0;
            sda_oe_d = ~tx_q[N-1];
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe            = sda_oe_q;
  assign busy              = busy_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_re    = re_q;

endmodule

// File: tb/tb_i2c_ram_slave.sv
// Directed + randomized bench for i2c_ram_slave: bit-banged I2C controller,
// behavioural RAM, and a byte-level reference model of memory and pointer.
module tb_i2c_ram_slave;
  import i2c_pkg::*;

  localparam int         Q    = 8;      // clk cycles per quarter SCL period
  localparam logic [6:0] DEV7 = 7'h50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy;
  logic sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_ram_slave_if #(.N(8)) mem_bus ();

  i2c_ram_slave #(.DEV_ADDR(7'h50), .N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .mem_bus (mem_bus)
  );

  always #5 clk = ~clk;

  // RAM instance model
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    if (mem_bus.mem_re) mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
  end

  // Strobe monitor
  logic [15:0] we_log [$];
  logic [7:0]  re_log [$];
  bit          both_seen = 1'b0;
  bit          oe_seen   = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_bus.mem_we) we_log.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
      if (mem_bus.mem_re) re_log.push_back(mem_bus.mem_addr);
      if (mem_bus.mem_we && mem_bus.mem_re) both_seen = 1'b1;
      if (sda_oe) oe_seen = 1'b1;
    end
  end

  // Reference model: byte memory plus persistent pointer
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr = 8'h00;
  logic [7:0] wq [$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output bit acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    acked = (b === 1'b0);
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack ? 1'b0 : 1'b1);
  endtask

  // Pointer load followed by the bytes queued in wq (empty wq = pointer only)
  task automatic i2c_write(input logic [7:0] p, input string tag);
    bit a;
    we_log.delete(); re_log.delete();
    i2c_start();
    write_byte({DEV7, 1'b0}, a);
    check({tag, " dev ack"}, 32'(a), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd1);
    write_byte(p, a);
    check({tag, " ptr ack"}, 32'(a), 32'd1);
    foreach (wq[i]) begin
      write_byte(wq[i], a);
      check({tag, " data ack"}, 32'(a), 32'd1);
    end
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    check({tag, " busy after stop"}, 32'(busy), 32'd0);
    check({tag, " write count"}, 32'(we_log.size()), 32'(wq.size()));
    check({tag, " no reads"}, 32'(re_log.size()), 32'd0);
    ref_ptr = p;
    foreach (wq[i]) begin
      if (i < we_log.size()) check({tag, " write"}, 32'(we_log[i]), 32'({ref_ptr, wq[i]}));
      ref_mem[ref_ptr] = wq[i];
      ref_ptr = ref_ptr + 8'd1;
    end
  endtask

  // Read n bytes (ACK all but the last); optionally set the pointer first
  task automatic i2c_read(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
    bit a;
    logic [7:0] d, ea;
    we_log.delete(); re_log.delete();
    if (set_ptr) begin
      i2c_start();
      write_byte({DEV7, 1'b0}, a);
      check({tag, " wr dev ack"}, 32'(a), 32'd1);
      write_byte(p, a);
      check({tag, " ptr ack"}, 32'(a), 32'd1);
      ref_ptr = p;
    end
    i2c_start();
    write_byte({DEV7, 1'b1}, a);
    check({tag, " rd dev ack"}, 32'(a), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, d);
      ea = ref_ptr + 8'(i);
      check({tag, " data"}, 32'(d), 32'(ref_mem[ea]));
    end
    check({tag, " sda released"}, 32'(sda_oe), 32'd0);
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    check({tag, " read count"}, 32'(re_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      ea = ref_ptr + 8'(i);
      if (i < re_log.size()) check({tag, " read addr"}, 32'(re_log[i]), 32'(ea));
    end
    check({tag, " no writes"}, 32'(we_log.size()), 32'd0);
    ref_ptr = ref_ptr + 8'(n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    logic [7:0] p;
    int n;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst sda_oe", 32'(sda_oe), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst we", 32'(mem_bus.mem_we), 32'd0);
    check("rst re", 32'(mem_bus.mem_re), 32'd0);
    check("rst addr", 32'(mem_bus.mem_addr), 32'd0);
    check("rst wdata", 32'(mem_bus.mem_wdata), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Write 0xAB, 0xCD at 0x10
    wq.delete(); wq.push_back(8'hAB); wq.push_back(8'hCD);
    i2c_write(8'h10, "write");

    // Random read with repeated START
    i2c_read(1'b1, 8'h10, 2, "rand read");

    // Address mismatch
    we_log.delete(); re_log.delete(); oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, a);
    check("mismatch dev ack", 32'(a), 32'd0);
    write_byte(8'h00, a);
    check("mismatch data ack", 32'(a), 32'd0);
    check("mismatch busy", 32'(busy), 32'd0);
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    check("mismatch sda_oe seen", 32'(oe_seen), 32'd0);
    check("mismatch writes", 32'(we_log.size()), 32'd0);
    check("mismatch reads", 32'(re_log.size()), 32'd0);

    // Pointer wrap
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    i2c_write(8'hFF, "wrap");
    i2c_read(1'b1, 8'hFF, 2, "wrap read");

    // Aborted data byte
    we_log.delete();
    i2c_start();
    write_byte({DEV7, 1'b0}, a);
    check("abort dev ack", 32'(a), 32'd1);
    write_byte(8'h30, a);
    check("abort ptr ack", 32'(a), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    check("abort writes", 32'(we_log.size()), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    ref_ptr = 8'h30;
    wq.delete(); wq.push_back(8'h77);
    i2c_write(8'h31, "after abort");

    // Randomized write / read-back / current-address read
    for (int it = 0; it < 3; it++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      i2c_write(p, "rnd wr");
      i2c_read(1'b1, p, n, "rnd rd");
      wq.delete();
      i2c_write(p, "rnd setptr");
      i2c_read(1'b0, 8'h00, 1, "rnd cur");
    end

    // Reset while driving a 0 data bit
    wq.delete(); wq.push_back(8'h3C);
    i2c_write(8'h20, "pre rst");
    i2c_start();
    write_byte({DEV7, 1'b0}, a);
    write_byte(8'h20, a);
    i2c_start();
    write_byte({DEV7, 1'b1}, a);
    check("midrd dev ack", 32'(a), 32'd1);
    check("midrd driving 0", 32'(sda_oe), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrd async sda_oe", 32'(sda_oe), 32'd0);
    check("midrd async busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 8'h00;
    i2c_stop();
    wq.delete(); wq.push_back(8'h5A);
    i2c_write(8'h05, "post rst");
    i2c_read(1'b1, 8'h05, 1, "post rst rd");

    check("we/re overlap", 32'(both_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
